// File: rtl/dram_lane_arbiter.sv
// Round-robin arbiter/sequencer sharing the 8-lane byte DRAM among NREQ requesters.
// One batched transaction in flight; fixed-latency DRAM timing tracked by a cycle counter.
module dram_lane_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned WR_DONE    = 21,
    parameter int unsigned RD_TIMEOUT = 63
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0]              req_rdwr,
    input  logic [NREQ-1:0][7:0]         req_en,
    input  logic [NREQ-1:0][7:0][63:0]   req_addr,
    input  logic [NREQ-1:0][7:0][7:0]    req_wdata,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [7:0][7:0]              rsp_rdata,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [7:0]                   dram_en,
    output logic                         dram_rdwr,
    output logic [7:0][63:0]             dram_addr,
    output logic [7:0][7:0]              dram_data_in,
    input  logic [7:0][7:0]              dram_data_out,
    input  logic [7:0]                   dram_valid
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_WAIT_WR,
        S_RESP
    } state_e;

    state_e                 state_q;
    logic [IDW-1:0]         rr_q;
    logic [IDW-1:0]         owner_q;
    logic                   rdwr_q;
    logic [7:0]             en_q;
    logic [7:0][63:0]       addr_q;
    logic [7:0][7:0]        wdata_q;
    logic [7:0][7:0]        rdata_q;
    logic                   err_q;
    logic [CW-1:0]          cyc_q;
    logic [7:0]             dram_en_q;
    logic [NREQ-1:0]        rsp_valid_q;

    logic                   grant_found;
    logic [IDW-1:0]         grant_id;
    logic [IDW-1:0]         sel;
    int unsigned            sum;
    logic [IDW-1:0]         rr_d;
    logic [NREQ-1:0]        owner_oh;
    logic [7:0][7:0]        rd_masked;

    // Search upward from the pointer with wrap-around; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = 0;
        sel         = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = 32'(rr_q) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            sel = IDW'(sum);
            if (!grant_found && req_valid[sel]) begin
                grant_found = 1'b1;
                grant_id    = sel;
            end
        end
    end

    always_comb begin
        rd_masked = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (en_q[i]) begin
                rd_masked[i] = dram_data_out[i];
            end
        end
    end

    assign rr_d      = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    assign owner_oh  = NREQ'(1) << owner_q;
    assign req_ready = (reset && state_q == S_IDLE && grant_found) ? (NREQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            rdwr_q      <= 1'b0;
            en_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cyc_q       <= '0;
            dram_en_q   <= '0;
            rsp_valid_q <= '0;
        end else begin
            dram_en_q   <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        owner_q   <= grant_id;
                        rr_q      <= rr_d;
                        rdwr_q    <= req_rdwr[grant_id];
                        en_q      <= req_en[grant_id];
                        addr_q    <= req_addr[grant_id];
                        wdata_q   <= req_wdata[grant_id];
                        rdata_q   <= '0;
                        err_q     <= 1'b0;
                        cyc_q     <= '0;
                        dram_en_q <= req_en[grant_id];
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cyc_q <= cyc_q + CW'(1);
                    if (en_q == '0) begin
                        rsp_valid_q <= owner_oh;
                        state_q     <= S_RESP;
                    end else if (rdwr_q) begin
                        state_q <= S_WAIT_RD;
                    end else begin
                        state_q <= S_WAIT_WR;
                    end
                end
                S_WAIT_RD: begin
                    cyc_q <= cyc_q + CW'(1);
                    // Valid data takes priority over a coincident timeout.
                    if (dram_valid != '0) begin
                        rdata_q     <= rd_masked;
                        rsp_valid_q <= owner_oh;
                        state_q     <= S_RESP;
                    end else if (cyc_q == CW'(RD_TIMEOUT)) begin
                        err_q       <= 1'b1;
                        rdata_q     <= '0;
                        rsp_valid_q <= owner_oh;
                        state_q     <= S_RESP;
                    end
                end
                S_WAIT_WR: begin
                    cyc_q <= cyc_q + CW'(1);
                    if (cyc_q == CW'(WR_DONE)) begin
                        rsp_valid_q <= owner_oh;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign busy         = (state_q != S_IDLE);
    assign dram_en      = dram_en_q;
    assign dram_rdwr    = rdwr_q;
    assign dram_addr    = addr_q;
    assign dram_data_in = wdata_q;

endmodule

// File: tb/tb_dram_lane_arbiter.sv
// Directed bench for dram_lane_arbiter with a 20-cycle-latency byte DRAM model.
// Expected values are hand-derived from the transaction timing (ISSUE at t, RESP at t+22 / t+64).
module tb_dram_lane_arbiter;

    localparam int unsigned NREQ = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_rdwr;
    logic [NREQ-1:0][7:0]       req_en;
    logic [NREQ-1:0][7:0][63:0] req_addr;
    logic [NREQ-1:0][7:0][7:0]  req_wdata;
    logic [NREQ-1:0]            rsp_valid;
    logic [7:0][7:0]            rsp_rdata;
    logic                       rsp_err;
    logic                       busy;
    logic [7:0]                 dram_en;
    logic                       dram_rdwr;
    logic [7:0][63:0]           dram_addr;
    logic [7:0][7:0]            dram_data_in;
    logic [7:0][7:0]            dram_data_out;
    logic [7:0]                 dram_valid;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc_cnt  = 0;

    dram_lane_arbiter #(.NREQ(NREQ), .WR_DONE(21), .RD_TIMEOUT(63)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rdwr     (req_rdwr),
        .req_en       (req_en),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .dram_en      (dram_en),
        .dram_rdwr    (dram_rdwr),
        .dram_addr    (dram_addr),
        .dram_data_in (dram_data_in),
        .dram_data_out(dram_data_out),
        .dram_valid   (dram_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // DRAM model: captures on the en pulse, returns read data 20 cycles later.
    logic [7:0] mem [0:255];
    logic       stuck = 1'b0;
    logic       pend;
    int         pend_cnt;
    logic [7:0] en_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend          <= 1'b0;
            pend_cnt      <= 0;
            en_hold       <= '0;
            dram_valid    <= '0;
            dram_data_out <= '0;
            mem[10]       <= 8'hAA;
            mem[20]       <= 8'hBB;
        end else begin
            dram_valid <= '0;
            if (dram_en != '0) begin
                if (dram_rdwr) begin
                    pend     <= !stuck;
                    pend_cnt <= 20;
                    en_hold  <= dram_en;
                    for (int i = 0; i < 8; i++)
                        dram_data_out[i] <= dram_en[i] ? mem[dram_addr[i][7:0]] : 8'hEE;
                end else begin
                    for (int i = 0; i < 8; i++)
                        if (dram_en[i]) mem[dram_addr[i][7:0]] <= dram_data_in[i];
                end
            end else if (pend) begin
                if (pend_cnt == 1) begin
                    dram_valid <= en_hold;
                    pend       <= 1'b0;
                end
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction from requester r; exp_lat is ISSUE-to-RESP in cycles.
    task automatic do_req(input int unsigned r, input logic rd, input logic [7:0] en,
                          input logic [7:0][63:0] addr, input logic [7:0][7:0] wd,
                          input logic [7:0][7:0] exp_rd, input logic exp_err,
                          input int unsigned exp_lat);
        int unsigned hs, pulses, waited;
        logic got_hs, got_rsp;
        @(negedge clk);
        req_rdwr[r]  = rd;
        req_en[r]    = en;
        req_addr[r]  = addr;
        req_wdata[r] = wd;
        req_valid[r] = 1'b1;
        got_hs = 1'b0;
        waited = 0;
        while (!got_hs && waited < 100) begin
            #1;
            if (req_ready[r]) got_hs = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check("handshake", 64'(got_hs), 64'd1);
        if (!got_hs) begin
            req_valid[r] = 1'b0;
            return;
        end
        check("ready_onehot", 64'(req_ready), 64'(4'b0001 << r));
        hs      = cyc_cnt;
        pulses  = 0;
        got_rsp = 1'b0;
        for (int k = 0; k < 100 && !got_rsp; k++) begin
            @(negedge clk);
            req_valid[r] = 1'b0;
            req_en[r]    = ~en;
            req_addr[r]  = '1;
            req_wdata[r] = '1;
            if (dram_en != '0) begin
                pulses++;
                check("dram_en", 64'(dram_en), 64'(en));
                check("dram_rdwr", 64'(dram_rdwr), 64'(rd));
                check("issue_cyc", 64'(cyc_cnt), 64'(hs + 1));
            end
            if (rsp_valid != '0) begin
                got_rsp = 1'b1;
                check("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << r));
                check("rsp_rdata", rsp_rdata, exp_rd);
                check("rsp_err", 64'(rsp_err), 64'(exp_err));
                check("rsp_lat", 64'(cyc_cnt - hs), 64'(exp_lat + 1));
            end
        end
        check("rsp_seen", 64'(got_rsp), 64'd1);
        check("en_pulses", 64'(pulses), 64'(en != 8'h00));
        @(negedge clk);
        check("rsp_clear", 64'(rsp_valid), 64'd0);
        check("err_clear", 64'(rsp_err), 64'd0);
        check("idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0][63:0] a;
        logic [7:0][7:0]  wd, e;
        int unsigned ng, seen;
        int unsigned gid [5];
        int unsigned gcyc [5];
        int unsigned exp_g [5];

        rst_n     = 1'b0;
        req_valid = '0;
        req_rdwr  = '0;
        req_en    = '0;
        req_addr  = '0;
        req_wdata = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_dram_en", 64'(dram_en), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_rdwr", 64'(dram_rdwr), 64'd0);
        check("rst_wdata", dram_data_in, 64'd0);
        check("rst_addr0", dram_addr[0], 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters held high: rotation 0,1,2,3,0 with 24-cycle spacing.
        for (int r = 0; r < 4; r++) begin
            req_rdwr[r]    = 1'b1;
            req_en[r]      = 8'h01;
            req_addr[r]    = '0;
            req_addr[r][0] = 64'd10;
        end
        req_valid = '1;
        ng = 0;
        for (int k = 0; k < 200 && ng < 5; k++) begin
            #1;
            check("ready_max1", 64'($countones(req_ready) <= 1), 64'd1);
            if (req_ready != '0) begin
                for (int b = 0; b < 4; b++) if (req_ready[b]) gid[ng] = b;
                gcyc[ng] = cyc_cnt;
                ng++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        check("rr_count", 64'(ng), 64'd5);
        exp_g = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && i < int'(ng); i++) check("rr_grant", 64'(gid[i]), 64'(exp_g[i]));
        for (int i = 1; i < 5 && i < int'(ng); i++) check("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd24);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        check("rr_drain", 64'(busy), 64'd0);

        // Sparse read, masked lanes must come back zero.
        a = '0; a[0] = 64'd10; a[2] = 64'd20;
        e = '0; e[0] = 8'hAA;  e[2] = 8'hBB;
        do_req(0, 1'b1, 8'h05, a, '0, e, 1'b0, 22);

        // Full-width write then read-back.
        for (int i = 0; i < 8; i++) begin
            a[i]  = 64'(100 + i);
            wd[i] = 8'(8'h11 * (i + 1));
        end
        do_req(1, 1'b0, 8'hFF, a, wd, '0, 1'b0, 22);
        do_req(1, 1'b1, 8'hFF, a, '0, wd, 1'b0, 22);

        // Empty lane mask: no DRAM access, response right after ISSUE.
        do_req(3, 1'b1, 8'h00, a, '0, '0, 1'b0, 1);

        // DRAM never answers: timeout error, then normal service resumes.
        stuck = 1'b1;
        a = '0; a[0] = 64'd10; a[2] = 64'd20;
        do_req(2, 1'b1, 8'h05, a, '0, '0, 1'b1, 64);
        stuck = 1'b0;
        do_req(0, 1'b1, 8'h05, a, '0, e, 1'b0, 22);

        // Mid-transaction reset: pointer sits at 3 after granting requester 2.
        stuck = 1'b1;
        do_req(2, 1'b1, 8'h05, a, '0, '0, 1'b1, 64);
        @(negedge clk);
        req_rdwr[2] = 1'b1; req_en[2] = 8'h05; req_addr[2] = a; req_valid[2] = 1'b1;
        #1;
        check("mid_ready", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        check("mid_rst_rdwr", 64'(dram_rdwr), 64'd0);
        check("mid_rst_addr", dram_addr[2], 64'd0);
        @(negedge clk);
        @(negedge clk);
        stuck = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen++;
        end
        check("mid_no_rsp", 64'(seen), 64'd0);
        req_rdwr[1] = 1'b1; req_en[1] = 8'h01;
        req_rdwr[3] = 1'b1; req_en[3] = 8'h01;
        req_valid = 4'b1010;
        #1;
        check("ptr_after_rst", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        check("final_drain", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_lane_arbiter.md
Name: dram_lane_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 8-lane byte DRAM model among NREQ requesters.
- Accepts one batched request (up to 8 byte lanes, all read or all write) at a time and drives the DRAM en/rdwr/addr/data_in lines.
- Tracks the fixed DRAM latency, captures read data, and returns a one-cycle response to the requester that owns the transaction.
- Sits between the decode engines and the DRAM.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WR_DONE, 21, cycle-counter value at which a write is deemed complete (DRAM wait of 20 plus its turnaround).
- RD_TIMEOUT, 63, cycle-counter value at which a read with no dram_valid is aborted with an error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  request accepted this cycle (at most one bit set)
- req_rdwr  in  NREQ  1 = read, 0 = write, per requester
- req_en  in  NREQ x 8  lane enables, per requester
- req_addr  in  NREQ x 8 x 64  lane byte addresses
- req_wdata  in  NREQ x 8 x 8  lane write bytes
- rsp_valid  out  NREQ  one-hot response pulse to the owning requester
- rsp_rdata  out  8 x 8  read bytes; zero for disabled lanes and for writes
- rsp_err  out  1  read timeout, qualified by rsp_valid
- busy  out  1  high in any state other than IDLE
- dram_en  out  8  DRAM lane enables
- dram_rdwr  out  1  DRAM read/write select
- dram_addr  out  8 x 64  DRAM lane addresses
- dram_data_in  out  8 x 8  DRAM write bytes
- dram_data_out  in  8 x 8  DRAM read bytes
- dram_valid  in  8  DRAM read-valid lanes

Behaviour:
- Reset (reset = 0, asynchronous):
  - State IDLE; rr pointer = 0.
  - req_ready, rsp_valid, dram_en, busy = 0.
  - rsp_err = 0; rsp_rdata, captured address/data/enables and dram_rdwr = 0.
- States: IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP.
- IDLE:
  - Grant g is the first requester with req_valid = 1, searching upward from rr pointer with wrap-around (e.g. pointer 2 with NREQ = 4 checks 2, 3, 0, 1).
  - req_ready[g] = 1, combinational from req_valid and the registered pointer.
  - On the handshake, capture the request fields and the owner id, set pointer = (g+1) mod NREQ, and move to ISSUE.
  - If the captured req_en is all zero, go directly to RESP: no DRAM access, rsp_rdata = 0.
- ISSUE:
  - Exactly one cycle with dram_en = captured en; cycle counter cyc = 0.
  - Next state is WAIT_RD if rdwr = 1, otherwise WAIT_WR.
  - dram_rdwr, dram_addr and dram_data_in are driven from capture registers and held stable from ISSUE until the transaction leaves RESP.
  - dram_en = 0 in every state except ISSUE.
- cyc increments every cycle in WAIT_RD and WAIT_WR.
- WAIT_RD:
  - When dram_valid != 0, latch rsp_rdata[i] = dram_data_out[i] for lanes with captured en[i] = 1, and 0 for all other lanes; go to RESP.
  - If cyc == RD_TIMEOUT with no valid, set rsp_err = 1, rsp_rdata = 0, and go to RESP.
  - If valid and timeout occur in the same cycle, valid wins.
- WAIT_WR: when cyc == WR_DONE, go to RESP.
- RESP:
  - Exactly one cycle with rsp_valid[owner] = 1, then IDLE.
  - rsp_err holds its value during RESP and clears on leaving.
- Timing with DRAM latency 20 and ISSUE at cycle t:
  - dram_valid arrives at t+21.
  - RESP is at t+22 for both reads and writes.
  - IDLE at t+23, so the earliest next ISSUE is t+24. The DRAM is back in its idle state by t+22, so no re-trigger is possible.
- Requests are never accepted outside IDLE.
  - A requester whose req_valid drops before it is granted is simply skipped.
  - Request inputs are ignored after capture.
- Only the granted requester is considered per handshake. A requester with req_valid held high is served at most once per round-robin rotation while others are pending.
- A mid-operation reset abandons the transaction with no response. The system resets the DRAM alongside this block.

Test Plan:
- Single read, requester 0, en = 8'h05, addr lanes 0/2 = 10/20, memory preloaded with 8'hAA/8'hBB -> dram_en = 8'h05 for exactly one cycle; rsp_valid = 4'b0001 at ISSUE+22; rsp_rdata lane0 = AA, lane2 = BB, other lanes 0; rsp_err = 0.
- Write then read-back, requester 1, en = 8'hFF, addr = 100..107, wdata = 8'h11..8'h88 -> write rsp_valid = 4'b0010 at ISSUE+22 with rsp_rdata = 0; a following read returns 8'h11..8'h88.
- All four requesters assert req_valid simultaneously, held high -> grants in order 0, 1, 2, 3, 0; ISSUE-to-ISSUE spacing is 24 cycles; at most one req_ready bit set per cycle.
- Request with req_en = 0 -> no dram_en pulse; rsp_valid two cycles after the handshake; rsp_rdata = 0.
- Read with the DRAM held in its reset (dram_valid stuck at 0) -> rsp_err = 1 with rsp_valid at ISSUE+64; the next request is accepted afterwards.
- Assert reset = 0 during WAIT_RD -> outputs return to reset values immediately; no rsp_valid; pointer = 0 after release.
